// File: rtl/parity_stream_checker.sv
// ---------------------------------------------------------------------------
// parity_stream_checker
//
// Streaming XOR-parity generator/checker over multi-beat packets. Each
// accepted beat is reduced to one parity bit and folded into a running
// accumulator. One registered result (parity, mismatch flag, beat count) is
// produced per packet, one cycle after its last beat is accepted. A
// saturating counter keeps the total number of mismatches since reset.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid && ready are both 1. A held result (out_valid) keeps its fields
// constant until it is accepted. The only backpressure on the input is a held
// result that is not being accepted in the current cycle.
//
// Ports
//   clk          in   1       clock, rising edge
//   reset        in   1       synchronous, active-high
//   in_valid     in   1       beat valid
//   in_ready     out  1       beat can be accepted this cycle
//   in_data      in   WIDTH   beat data
//   in_last      in   1       final beat of packet
//   in_par       in   1       expected parity, used on the last beat
//   odd_mode     in   1       0 = even, 1 = odd; taken from the first beat
//   check_en     in   1       compare against in_par; taken from last beat
//   out_valid    out  1       result valid, held until out_ready
//   out_ready    in   1       result accepted this cycle
//   out_parity   out  1       generated parity of the packet
//   out_err      out  1       parity mismatch (0 when check_en was 0)
//   out_beats    out  BEAT_W  beats in packet, saturating
//   err_count    out  ERR_W   mismatches since reset, saturating
//   o_dbg_state  out  1       packet FSM state (0 = IDLE, 1 = ACCUM)
// ---------------------------------------------------------------------------
module parity_stream_checker #(
    parameter int WIDTH  = 8,
    parameter int BEAT_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    input  logic              in_par,
    input  logic              odd_mode,
    input  logic              check_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_parity,
    output logic              out_err,
    output logic [BEAT_W-1:0] out_beats,
    output logic [ERR_W-1:0]  err_count,
    output logic              o_dbg_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_acc;
    logic [BEAT_W-1:0]   r_beats;
    logic                r_mode;

    logic                r_out_valid;
    logic                r_out_parity;
    logic                r_out_err;
    logic [BEAT_W-1:0]   r_out_beats;
    logic [ERR_W-1:0]    r_err_count;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_first;
    logic                w_load;
    logic                w_acc_next;
    logic [BEAT_W-1:0]   w_beats_next;
    logic                w_mode_next;
    logic                w_parity;
    logic                w_err;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic. A single-beat packet leaves the FSM in IDLE.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = in_last ? ST_IDLE : ST_ACCUM;
        end
    end

    // ---------------------------------------------------------------------
    // Output / datapath combinational logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_in_ready   = !r_out_valid || out_ready;
        w_accept     = in_valid && w_in_ready;
        // A beat accepted in IDLE opens a packet and restarts accumulation.
        w_first      = (r_state == ST_IDLE);
        w_load       = w_accept && in_last;
        w_acc_next   = w_first ? (^in_data) : (r_acc ^ (^in_data));
        w_beats_next = r_beats;
        if (w_first) begin
            w_beats_next = BEAT_W'(1);
        end else if (!(&r_beats)) begin
            w_beats_next = r_beats + BEAT_W'(1);
        end
        // Mode is frozen at the first beat; later odd_mode changes are ignored.
        w_mode_next  = w_first ? odd_mode : r_mode;
        w_parity     = w_acc_next ^ w_mode_next;
        w_err        = check_en && (w_parity != in_par);
    end

    // ---------------------------------------------------------------------
    // Accumulator and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc        <= 1'b0;
            r_beats      <= '0;
            r_mode       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_parity <= 1'b0;
            r_out_err    <= 1'b0;
            r_out_beats  <= '0;
            r_err_count  <= '0;
        end else begin
            if (w_accept) begin
                r_acc   <= w_acc_next;
                r_beats <= w_beats_next;
                r_mode  <= w_mode_next;
            end
            // A new result may load in the same cycle the old one is taken,
            // so out_valid stays high across back-to-back packets.
            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_parity <= w_parity;
                r_out_err    <= w_err;
                r_out_beats  <= w_beats_next;
                if (w_err && !(&r_err_count)) begin
                    r_err_count <= r_err_count + ERR_W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_parity  = r_out_parity;
    assign out_err     = r_out_err;
    assign out_beats   = r_out_beats;
    assign err_count   = r_err_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_parity_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_stream_checker
//
// Directed bench. Drivers push the hand-computed result of each packet into
// exp_q when its last beat is accepted; an independent monitor pops and
// compares every result the DUT hands over. The DUT is built with ERR_W=2 so
// error-counter saturation is reachable in a few packets.
// ---------------------------------------------------------------------------
module tb_parity_stream_checker;

    localparam int W = 12;  // {parity, err, beats[7:0], err_count[1:0]}

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_par;
    logic       odd_mode;
    logic       check_en;
    logic       out_valid;
    logic       out_ready;
    logic       out_parity;
    logic       out_err;
    logic [7:0] out_beats;
    logic [1:0] err_count;
    logic       dbg_state;

    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_cnt;
    logic [7:0]   pkt[4];
    int           n_vec;
    int           n_bad;

    parity_stream_checker #(.WIDTH(8), .BEAT_W(8), .ERR_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_par     (in_par),
        .odd_mode   (odd_mode),
        .check_en   (check_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_err    (out_err),
        .out_beats  (out_beats),
        .err_count  (err_count),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = 2'd0;
        @(negedge clk);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_parity", 32'(out_parity), 32'd0);
        check("rst_out_beats",  32'(out_beats),  32'd0);
        check("rst_err_count",  32'(err_count),  32'd0);
        check("rst_state",      32'(dbg_state),  32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- drivers ----------------
    // Call between a rising edge and the next falling edge.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic par,
                             input logic odd, input logic chk);
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_par   = par;
        odd_mode = odd;
        check_en = chk;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL beat_accept: got in_ready 0 for 100 cycles, need 1");
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends pkt[0..n-1]; odd_mode is inverted after the first beat to show
    // that only the first beat's mode counts.
    task automatic send_pkt(input int n, input logic odd, input logic par, input logic chk,
                            input logic e_par, input logic e_err, input logic [7:0] e_beats);
        for (int i = 0; i < n; i++) begin
            send_beat(pkt[i], (i == n - 1), par, (i == 0) ? odd : ~odd, chk);
        end
        if (e_err && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
        exp_q.push_back({e_par, e_err, e_beats, exp_cnt});
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_result: got par %0b beats %0d, need none",
                         out_parity, out_beats);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("result", 32'({out_parity, out_err, out_beats, err_count}), 32'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0; n_bad = 0; exp_cnt = 2'd0;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        in_par = 1'b0; odd_mode = 1'b0; check_en = 1'b0; out_ready = 1'b1;
        do_reset();

        // 1: single beat 01 even, par 1 -> parity 1, err 0, beats 1
        pkt[0] = 8'h01;
        send_pkt(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        @(negedge clk);
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        // 2: walking one, even -> 0, odd -> 1
        pkt[0] = 8'h01; pkt[1] = 8'h02; pkt[2] = 8'h04; pkt[3] = 8'h08;
        send_pkt(4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        send_pkt(4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4);
        // 3: mismatch 03 par 1 -> err, count 1; then check off -> no err
        pkt[0] = 8'h03;
        send_pkt(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
        send_pkt(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        // all-zero odd -> 1; 3 beats FF,80,00 even -> 9 ones -> 1
        pkt[0] = 8'h00;
        send_pkt(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        pkt[0] = 8'hFF; pkt[1] = 8'h80; pkt[2] = 8'h00;
        send_pkt(3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
        drain();

        // 4: backpressure, result 07 even held for 5 cycles
        out_ready = 1'b0;
        pkt[0] = 8'h07;
        send_pkt(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid",  32'(out_valid),  32'd1);
            check("bp_in_ready",   32'(in_ready),   32'd0);
            check("bp_out_parity", 32'(out_parity), 32'd1);
            check("bp_out_beats",  32'(out_beats),  32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        // new last beat accepted in the same cycle the held result is taken
        pkt[0] = 8'h0F;
        send_pkt(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        drain();

        // 5: error counter saturation (ERR_W=2): 1,2,3,3,3
        do_reset();
        pkt[0] = 8'h03;
        for (int p = 0; p < 5; p++) begin
            send_pkt(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
        end
        drain();
        check("t5_err_count_sat", 32'(err_count), 32'd3);

        // 6: reset mid-packet, then single zero beat even
        send_beat(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
        send_beat(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("t6_state_accum", 32'(dbg_state), 32'd1);
        do_reset();
        pkt[0] = 8'h00;
        send_pkt(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        drain();
        repeat (5) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
